// File: rtl/rc_pwm_decoder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rc_pwm_decoder_pkg                                                   |
// | Shared defaults and channel FSM encoding for the RC PWM decoder.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package rc_pwm_decoder_pkg;

    localparam int C_CLK_DIV      = 50;
    localparam int C_MIN_US       = 988;
    localparam int C_SPAN_LOG2    = 10;
    localparam int C_MIN_VALID_US = 800;
    localparam int C_MAX_VALID_US = 2200;
    localparam int C_TIMEOUT_US   = 25000;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HIGH = 1'b1
    } ch_state_t;

endpackage : rc_pwm_decoder_pkg
`default_nettype wire

// File: rtl/rc_pwm_channel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rc_pwm_channel                                                       |
// | One channel: synchroniser, pulse FSM, width/timeout counters, scale. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rc_pwm_channel
    import rc_pwm_decoder_pkg::*;
#(
    parameter int              MIN_US       = C_MIN_US,
    parameter int              SPAN_LOG2    = C_SPAN_LOG2,
    parameter int              OUT_W        = 8,
    parameter int              MIN_VALID_US = C_MIN_VALID_US,
    parameter int              MAX_VALID_US = C_MAX_VALID_US,
    parameter int              TIMEOUT_US   = C_TIMEOUT_US,
    parameter logic [OUT_W-1:0] FAILSAFE    = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             pwm,
    output logic [OUT_W-1:0] value,
    output logic             valid,
    output logic             strobe,
    output logic             error
);

    localparam int                WCNT_W      = $clog2(MAX_VALID_US + 2);
    localparam int                TCNT_W      = $clog2(TIMEOUT_US + 1);
    localparam logic [WCNT_W-1:0] c_width_sat = WCNT_W'(MAX_VALID_US + 1);
    localparam logic [TCNT_W-1:0] c_to_sat    = TCNT_W'(TIMEOUT_US);
    localparam logic [TCNT_W-1:0] c_to_last   = TCNT_W'(TIMEOUT_US - 1);
    localparam int                c_span_max  = (1 << SPAN_LOG2) - 1;

    logic              r_sync1, r_sync2, r_prev, r_armed;
    logic [1:0]        r_live;
    ch_state_t         r_state, w_state_nx;
    logic [WCNT_W-1:0] r_width, w_width_nx, w_width_inc;
    logic [TCNT_W-1:0] r_to_cnt, w_to_nx;
    logic [OUT_W-1:0]  r_value, w_value_nx, w_scaled;
    logic              r_valid, r_strobe, r_error;
    logic              w_rise, w_fall, w_in_range, w_accept, w_reject;
    logic              w_to_hit, w_armed_nx, w_valid_nx;
    int                w_diff, w_clamp;

    assign value  = r_value;
    assign valid  = r_valid;
    assign strobe = r_strobe;
    assign error  = r_error;

    always_comb begin
        w_rise      = r_sync2 & ~r_prev;
        w_fall      = ~r_sync2 & r_prev;
        w_width_inc = (tick && (r_width != c_width_sat)) ? r_width + WCNT_W'(1) : r_width;
        w_in_range  = (int'(w_width_inc) >= MIN_VALID_US) && (int'(w_width_inc) <= MAX_VALID_US);

        // Clamp in the signed domain before dropping the low bits.
        w_diff = int'(w_width_inc) - MIN_US;
        if (w_diff < 0) begin
            w_clamp = 0;
        end else if (w_diff > c_span_max) begin
            w_clamp = c_span_max;
        end else begin
            w_clamp = w_diff;
        end
        w_scaled = OUT_W'(w_clamp >> (SPAN_LOG2 - OUT_W));

        // r_live masks the reset-value zeros so they never count as a real low.
        w_state_nx = r_state;
        w_width_nx = r_width;
        w_armed_nx = r_armed | (r_live[1] & ~r_sync2);
        w_accept   = 1'b0;
        w_reject   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise && r_armed) begin
                    w_state_nx = ST_HIGH;
                    w_width_nx = '0;
                end
            end
            ST_HIGH: begin
                w_width_nx = w_width_inc;
                if (w_fall) begin
                    w_state_nx = ST_IDLE;
                    w_accept   = w_in_range;
                    w_reject   = ~w_in_range;
                end else if (w_width_inc == c_width_sat) begin
                    w_state_nx = ST_IDLE;
                    w_reject   = 1'b1;
                    w_armed_nx = 1'b0;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase

        w_to_hit = tick && (r_to_cnt == c_to_last);
        if (w_accept) begin
            w_to_nx = '0;
        end else if (tick && (r_to_cnt != c_to_sat)) begin
            w_to_nx = r_to_cnt + TCNT_W'(1);
        end else begin
            w_to_nx = r_to_cnt;
        end

        // An acceptance in the threshold cycle takes priority over failsafe.
        if (w_accept) begin
            w_value_nx = w_scaled;
            w_valid_nx = 1'b1;
        end else if (w_to_hit) begin
            w_value_nx = FAILSAFE;
            w_valid_nx = 1'b0;
        end else begin
            w_value_nx = r_value;
            w_valid_nx = r_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_prev   <= 1'b0;
            r_live   <= '0;
            r_armed  <= 1'b0;
            r_state  <= ST_IDLE;
            r_width  <= '0;
            r_to_cnt <= '0;
            r_value  <= FAILSAFE;
            r_valid  <= 1'b0;
            r_strobe <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_sync1  <= pwm;
            r_sync2  <= r_sync1;
            r_prev   <= r_sync2;
            r_live   <= {r_live[0], 1'b1};
            r_armed  <= w_armed_nx;
            r_state  <= w_state_nx;
            r_width  <= w_width_nx;
            r_to_cnt <= w_to_nx;
            r_value  <= w_value_nx;
            r_valid  <= w_valid_nx;
            r_strobe <= w_accept;
            r_error  <= w_reject;
        end
    end

endmodule : rc_pwm_channel
`default_nettype wire

// File: rtl/rc_pwm_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rc_pwm_decoder                                                       |
// | Multi-channel RC PWM decoder: shared 1 us prescaler + channel array. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rc_pwm_decoder
    import rc_pwm_decoder_pkg::*;
#(
    parameter int               NUM_CH       = 4,
    parameter int               CLK_DIV      = C_CLK_DIV,
    parameter int               MIN_US       = C_MIN_US,
    parameter int               SPAN_LOG2    = C_SPAN_LOG2,
    parameter int               OUT_W        = 8,
    parameter int               MIN_VALID_US = C_MIN_VALID_US,
    parameter int               MAX_VALID_US = C_MAX_VALID_US,
    parameter int               TIMEOUT_US   = C_TIMEOUT_US,
    parameter logic [OUT_W-1:0] FAILSAFE     = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       pwm_in,
    output logic [NUM_CH*OUT_W-1:0] ch_value,
    output logic [NUM_CH-1:0]       ch_valid,
    output logic [NUM_CH-1:0]       ch_strobe,
    output logic [NUM_CH-1:0]       ch_error
);

    localparam int DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0] r_div;
    logic             w_tick;

    assign w_tick = (r_div == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        rc_pwm_channel #(
            .MIN_US       (MIN_US),
            .SPAN_LOG2    (SPAN_LOG2),
            .OUT_W        (OUT_W),
            .MIN_VALID_US (MIN_VALID_US),
            .MAX_VALID_US (MAX_VALID_US),
            .TIMEOUT_US   (TIMEOUT_US),
            .FAILSAFE     (FAILSAFE)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .tick   (w_tick),
            .pwm    (pwm_in[g]),
            .value  (ch_value[g*OUT_W +: OUT_W]),
            .valid  (ch_valid[g]),
            .strobe (ch_strobe[g]),
            .error  (ch_error[g])
        );
    end

endmodule : rc_pwm_decoder
`default_nettype wire

// File: tb/tb_rc_pwm_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rc_pwm_decoder                                                    |
// | Self-checking bench: vector table, corner sequences, random rounds.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_rc_pwm_decoder;

    localparam int D = 2;
    localparam int T = 4000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  pwm_in;
    logic [31:0] ch_value;
    logic [3:0]  ch_valid, ch_strobe, ch_error;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int wq[4];
    int n_str[4], n_err[4], str_rel[4], str_val[4], err_at[4], fall_cyc[4];
    int m_val[4], m_acc[4];

    typedef struct {
        int w;
        int strobes;
        int errors;
        int value;
        int valid;
    } vec_t;
    vec_t tbl[10];

    rc_pwm_decoder #(
        .NUM_CH     (4),
        .CLK_DIV    (D),
        .OUT_W      (8),
        .TIMEOUT_US (T)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pwm_in    (pwm_in),
        .ch_value  (ch_value),
        .ch_valid  (ch_valid),
        .ch_strobe (ch_strobe),
        .ch_error  (ch_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ref_scale(input int w);
        int d;
        d = w - 988;
        if (d < 0) d = 0;
        if (d > 1023) d = 1023;
        return d / 4;
    endfunction

    function automatic int ref_accept(input int w);
        return (w >= 800 && w <= 2200) ? 1 : 0;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Pulses every channel with wq[i] > 0 (width in us), all rising together.
    task automatic run_pulses();
        int maxc;
        maxc = 0;
        for (int i = 0; i < 4; i++) begin
            n_str[i] = 0; n_err[i] = 0; str_rel[i] = -1;
            str_val[i] = -1; err_at[i] = -1; fall_cyc[i] = 0;
            if (wq[i] * D > maxc) maxc = wq[i] * D;
        end
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) if (wq[i] > 0) pwm_in[i] = 1'b1;
        for (int c = 1; c <= maxc + 8; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) begin
                if (ch_strobe[i]) begin
                    n_str[i]++;
                    str_rel[i] = c - wq[i] * D;
                    str_val[i] = int'(ch_value[i*8 +: 8]);
                end
                if (ch_error[i]) begin
                    n_err[i]++;
                    err_at[i] = c;
                end
                if (wq[i] > 0 && c == wq[i] * D) begin
                    pwm_in[i]   = 1'b0;
                    fall_cyc[i] = cyc;
                end
            end
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, e, n, elapsed, acc, expv;
        bit dropped;
        int sim_exp[4];

        tbl[0] = '{1500, 1, 0, 128, 1};
        tbl[1] = '{1000, 1, 0,   3, 1};
        tbl[2] = '{2100, 1, 0, 255, 1};
        tbl[3] = '{ 900, 1, 0,   0, 1};
        tbl[4] = '{ 800, 1, 0,   0, 1};
        tbl[5] = '{1500, 1, 0, 128, 1};
        tbl[6] = '{ 400, 0, 1, 128, 1};
        tbl[7] = '{2300, 0, 1, 128, 1};
        tbl[8] = '{2200, 1, 0, 255, 1};
        tbl[9] = '{2201, 0, 1, 255, 1};
        sim_exp = '{28, 78, 178, 228};

        // Reset with ch0 held high: the pulse tail after release must be ignored.
        rst_n  = 1'b0;
        pwm_in = 4'b0001;
        repeat (3) @(posedge clk);
        #1;
        check("reset_value",  int'(ch_value),  0);
        check("reset_valid",  int'(ch_valid),  0);
        check("reset_strobe", int'(ch_strobe), 0);
        check("reset_error",  int'(ch_error),  0);
        rst_n = 1'b1;
        s = 0; e = 0;
        for (int c = 1; c <= 300 * D + 10; c++) begin
            @(posedge clk); #1;
            if (ch_strobe[0]) s++;
            if (ch_error[0])  e++;
            if (c == 300 * D) pwm_in[0] = 1'b0;
        end
        check("unarmed_strobe", s, 0);
        check("unarmed_error",  e, 0);

        for (int k = 0; k < 10; k++) begin
            wq = '{tbl[k].w, 0, 0, 0};
            run_pulses();
            check($sformatf("tbl%0d_w%0d_strobes", k, tbl[k].w), n_str[0], tbl[k].strobes);
            check($sformatf("tbl%0d_w%0d_errors",  k, tbl[k].w), n_err[0], tbl[k].errors);
            if (tbl[k].strobes == 1)
                check($sformatf("tbl%0d_w%0d_latency", k, tbl[k].w), str_rel[0], 3);
            check($sformatf("tbl%0d_w%0d_value", k, tbl[k].w), int'(ch_value[7:0]), tbl[k].value);
            check($sformatf("tbl%0d_w%0d_valid", k, tbl[k].w), int'(ch_valid[0]), tbl[k].valid);
            if (k == 0) begin
                check("others_value", int'(ch_value[31:8]), 0);
                check("others_valid", int'(ch_valid[3:1]), 0);
            end
        end

        // Stuck high: single error once 2201 us of high time is counted.
        wq = '{3000, 0, 0, 0};
        run_pulses();
        check("stuck_strobes", n_str[0], 0);
        check("stuck_errors",  n_err[0], 1);
        check($sformatf("stuck_err_cycle_%0d_in_window", err_at[0]),
              int'(err_at[0] >= 3 + 2200 * D + 1 && err_at[0] <= 3 + 2201 * D), 1);
        wq = '{1500, 0, 0, 0};
        run_pulses();
        check("rearm_strobes", n_str[0], 1);
        check("rearm_value",   int'(ch_value[7:0]), 128);
        check("rearm_valid",   int'(ch_valid[0]), 1);

        // Silence until the timeout threshold.
        n = 0; dropped = 1'b0;
        while (!dropped && n < T * D + 20) begin
            @(posedge clk); #1;
            n++;
            if (!ch_valid[0]) dropped = 1'b1;
        end
        elapsed = cyc - (fall_cyc[0] + 3);
        check("timeout_dropped", int'(dropped), 1);
        check($sformatf("timeout_after_%0d_cycles_in_window", elapsed),
              int'(elapsed >= (T - 1) * D + 1 && elapsed <= T * D), 1);
        check("timeout_value",  int'(ch_value[7:0]), 0);
        check("timeout_strobe", int'(ch_strobe[0]), 0);
        wq = '{1000, 0, 0, 0};
        run_pulses();
        check("restore_strobes", n_str[0], 1);
        check("restore_value",   int'(ch_value[7:0]), 3);
        check("restore_valid",   int'(ch_valid[0]), 1);

        wq = '{1100, 1300, 1700, 1900};
        run_pulses();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("sim_ch%0d_strobes", i), n_str[i], 1);
            check($sformatf("sim_ch%0d_errors",  i), n_err[i], 0);
            check($sformatf("sim_ch%0d_latency", i), str_rel[i], 3);
            check($sformatf("sim_ch%0d_value",   i), str_val[i], sim_exp[i]);
            m_val[i] = sim_exp[i];
            m_acc[i] = fall_cyc[i] + 3;
        end

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++) wq[i] = int'($urandom_range(2300, 700));
            run_pulses();
            for (int i = 0; i < 4; i++) begin
                acc = ref_accept(wq[i]);
                check($sformatf("rnd%0d_ch%0d_w%0d_strobes", r, i, wq[i]), n_str[i], acc);
                check($sformatf("rnd%0d_ch%0d_w%0d_errors",  r, i, wq[i]), n_err[i], 1 - acc);
                if (acc == 1) begin
                    expv = ref_scale(wq[i]);
                    check($sformatf("rnd%0d_ch%0d_w%0d_value",   r, i, wq[i]), str_val[i], expv);
                    check($sformatf("rnd%0d_ch%0d_w%0d_latency", r, i, wq[i]), str_rel[i], 3);
                    m_val[i] = expv;
                    m_acc[i] = fall_cyc[i] + 3;
                end
                elapsed = cyc - m_acc[i];
                if (elapsed <= (T - 1) * D) begin
                    check($sformatf("rnd%0d_ch%0d_valid", r, i), int'(ch_valid[i]), 1);
                    check($sformatf("rnd%0d_ch%0d_held",  r, i), int'(ch_value[i*8 +: 8]), m_val[i]);
                end else if (elapsed >= T * D) begin
                    check($sformatf("rnd%0d_ch%0d_valid", r, i), int'(ch_valid[i]), 0);
                    check($sformatf("rnd%0d_ch%0d_held",  r, i), int'(ch_value[i*8 +: 8]), 0);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rc_pwm_decoder
`default_nettype wire
